// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared state and move encodings for the falling-block engine
package tetris_pkg;

    typedef enum logic [2:0] {
        SPAWN,
        FALL,
        LOCK,
        CLEAR,
        OVER
    } state_t;

    localparam logic [1:0] MOVE_NONE  = 2'b00;
    localparam logic [1:0] MOVE_LEFT  = 2'b01;
    localparam logic [1:0] MOVE_RIGHT = 2'b10;
    localparam logic [1:0] MOVE_DROP  = 2'b11;

endpackage

// File: rtl/tetris_row_clear.sv
// rtl/tetris_row_clear.sv - lowest full row detection and one-row collapse of the field
module tetris_row_clear #(
    parameter int COLS = 4,
    parameter int ROWS = 8
) (
    input  logic [COLS*ROWS-1:0] field,
    output logic                 any_full,
    output logic [COLS*ROWS-1:0] field_shifted
);

    localparam int ROW_W = $clog2(ROWS);

    logic [ROW_W-1:0] full_row;

    // Ascending scan: the last full row seen is the lowest one on screen
    always_comb begin
        any_full = 1'b0;
        full_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (&field[r*COLS +: COLS]) begin
                any_full = 1'b1;
                full_row = ROW_W'(r);
            end
        end
    end

    // Rows above the removed one drop by one; row 0 refills empty, rows below stay
    always_comb begin
        field_shifted = field;
        field_shifted[0 +: COLS] = '0;
        for (int r = 1; r < ROWS; r++) begin
            if (int'(full_row) >= r) begin
                field_shifted[r*COLS +: COLS] = field[(r-1)*COLS +: COLS];
            end
        end
    end

endmodule

// File: rtl/tetris_board_engine.sv
// rtl/tetris_board_engine.sv - falling 1x1 piece engine with gravity, hard drop, row clear and score
module tetris_board_engine #(
    parameter int COLS      = 4,
    parameter int ROWS      = 8,
    parameter int SPAWN_COL = 1,
    parameter int FALL_DIV  = 1,
    parameter int SCORE_W   = 8
) (
    input  logic                 in_clk,
    input  logic                 in_restart,
    input  logic [1:0]           in_move,
    output logic [COLS*ROWS-1:0] out_board,
    output logic [SCORE_W-1:0]   out_score,
    output logic                 out_lock,
    output logic                 out_game_over
);

    import tetris_pkg::*;

    localparam int N      = COLS * ROWS;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int TICK_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(FALL_DIV - 1);
    localparam logic [N-1:0]      BIT0     = {{(N-1){1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [N-1:0]       field, field_n, field_shifted, board_n;
    logic               piece_valid, valid_n, any_full;
    logic [ROW_W-1:0]   pr, r_n, drop_row;
    logic [COL_W-1:0]   pc, c_n;
    logic [TICK_W-1:0]  tick, tick_n;
    logic [SCORE_W-1:0] score_n;

    // Out-of-range coordinates shift everything away and read as empty
    function automatic logic cell_at(input logic [N-1:0] f, input int r, input int c);
        logic [N-1:0] s;
        s = f >> (r * COLS + c);
        return s[0];
    endfunction

    tetris_row_clear #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_row_clear (
        .field        (field),
        .any_full     (any_full),
        .field_shifted(field_shifted)
    );

    // Hard drop target: deepest empty cell below the piece before the first blocker
    always_comb begin
        logic blocked;
        blocked  = 1'b0;
        drop_row = pr;
        for (int r = 1; r < ROWS; r++) begin
            if (r > int'(pr) && !blocked) begin
                if (cell_at(field, r, int'(pc))) blocked = 1'b1;
                else drop_row = ROW_W'(r);
            end
        end
    end

    // Next-state, piece motion, field update and score
    always_comb begin
        state_n = state;
        field_n = field;
        valid_n = piece_valid;
        r_n     = pr;
        c_n     = pc;
        tick_n  = tick;
        score_n = out_score;
        case (state)
            SPAWN: begin
                if (cell_at(field, 0, SPAWN_COL)) begin
                    state_n = OVER;
                end else begin
                    valid_n = 1'b1;
                    r_n     = '0;
                    c_n     = COL_W'(SPAWN_COL);
                    tick_n  = '0;
                    state_n = FALL;
                end
            end
            FALL: begin
                if (in_move == MOVE_DROP) begin
                    r_n     = drop_row;
                    state_n = LOCK;
                end else begin
                    if (in_move == MOVE_LEFT && pc != '0 &&
                        !cell_at(field, int'(pr), int'(pc) - 1)) begin
                        c_n = pc - 1'b1;
                    end else if (in_move == MOVE_RIGHT && int'(pc) < COLS - 1 &&
                                 !cell_at(field, int'(pr), int'(pc) + 1)) begin
                        c_n = pc + 1'b1;
                    end
                    // gravity looks at the column the piece occupies after the lateral move
                    if (tick == TICK_MAX) begin
                        tick_n = '0;
                        if (int'(pr) == ROWS - 1 || cell_at(field, int'(pr) + 1, int'(c_n))) begin
                            state_n = LOCK;
                        end else begin
                            r_n = pr + 1'b1;
                        end
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
            end
            LOCK: begin
                field_n = field | (BIT0 << (int'(pr) * COLS + int'(pc)));
                valid_n = 1'b0;
                state_n = CLEAR;
            end
            CLEAR: begin
                if (any_full) begin
                    field_n = field_shifted;
                    if (out_score != {SCORE_W{1'b1}}) score_n = out_score + 1'b1;
                end else begin
                    state_n = SPAWN;
                end
            end
            OVER: begin
                state_n = OVER;
            end
            default: begin
                state_n = SPAWN;
            end
        endcase
        board_n = field_n | (valid_n ? (BIT0 << (int'(r_n) * COLS + int'(c_n))) : '0);
    end

    // State and registered outputs; restart clears everything at once
    always_ff @(posedge in_clk or posedge in_restart) begin
        if (in_restart) begin
            state         <= SPAWN;
            field         <= '0;
            piece_valid   <= 1'b0;
            pr            <= '0;
            pc            <= '0;
            tick          <= '0;
            out_board     <= '0;
            out_score     <= '0;
            out_lock      <= 1'b0;
            out_game_over <= 1'b0;
        end else begin
            state         <= state_n;
            field         <= field_n;
            piece_valid   <= valid_n;
            pr            <= r_n;
            pc            <= c_n;
            tick          <= tick_n;
            out_board     <= board_n;
            out_score     <= score_n;
            out_lock      <= (state == LOCK);
            out_game_over <= (state_n == OVER);
        end
    end

endmodule

// File: tb/tb_tetris_board_engine.sv
// tb/tb_tetris_board_engine.sv - directed scoreboard bench for the falling-block engine
module tb_tetris_board_engine;

    logic        clk = 1'b0;
    logic        rst, rst4;
    logic [1:0]  mv, mv4;
    logic [31:0] board, board4;
    logic [7:0]  score, score4;
    logic        lock, lock4, over, over4;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] board;
        logic [7:0]  score;
    } lock_exp_t;

    lock_exp_t lock_q[$];

    logic [31:0] col_tab [8] = '{32'h2000_0000, 32'h2200_0000, 32'h2220_0000, 32'h2222_0000,
                                 32'h2222_2000, 32'h2222_2200, 32'h2222_2220, 32'h2222_2222};

    always #5 clk = ~clk;

    tetris_board_engine dut (
        .in_clk       (clk),
        .in_restart   (rst),
        .in_move      (mv),
        .out_board    (board),
        .out_score    (score),
        .out_lock     (lock),
        .out_game_over(over)
    );

    tetris_board_engine #(.FALL_DIV(4)) dut4 (
        .in_clk       (clk),
        .in_restart   (rst4),
        .in_move      (mv4),
        .out_board    (board4),
        .out_score    (score4),
        .out_lock     (lock4),
        .out_game_over(over4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every lock pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (lock === 1'b1) begin
            if (lock_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lock_unexpected: got lock with board %h expected no lock", board);
            end else begin
                lock_exp_t e;
                e = lock_q.pop_front();
                check("lock_board", board, e.board);
                check("lock_score", 32'(score), 32'(e.score));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mv  = 2'b00;
        rst = 1'b1;
        #1;
        check("rst_board", board, 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_lock", 32'(lock), 32'h0);
        check("rst_over", 32'(over), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_lock(input string name);
        int n;
        n = 0;
        while (lock !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (lock !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no lock in %0d cycles expected a lock", name, n);
        end
    endtask

    task automatic play(input logic [1:0] m, input int hold, input logic [31:0] lb,
                        input logic [7:0] ls, input string name);
        lock_q.push_back({lb, ls});
        mv = m;
        for (int i = 0; i < hold; i++) tick();
        mv = 2'b00;
        wait_lock(name);
    endtask

    task automatic finish_piece(input int n_clear);
        repeat (n_clear + 2) tick();
    endtask

    initial begin
        rst  = 1'b1;
        rst4 = 1'b1;
        mv   = 2'b00;
        mv4  = 2'b00;

        // single piece, no input
        do_reset();
        tick();
        check("a_spawn", board, 32'h0000_0002);
        lock_q.push_back({32'h2000_0000, 8'd0});
        for (int r = 1; r < 8; r++) begin
            tick();
            check("a_fall", board, 32'h2 << (4 * r));
        end
        tick();
        check("a_bottom_board", board, 32'h2000_0000);
        check("a_bottom_lock", 32'(lock), 32'h0);
        tick();
        tick();
        check("a_clear_board", board, 32'h2000_0000);
        check("a_clear_lock", 32'(lock), 32'h0);
        tick();
        check("a_respawn", board, 32'h2000_0002);

        // left held: clamps at column 0
        do_reset();
        tick();
        mv = 2'b01;
        tick();
        check("b_left1", board, 32'h0000_0010);
        tick();
        check("b_left2", board, 32'h0000_0100);
        tick();
        check("b_left3", board, 32'h0000_1000);
        lock_q.push_back({32'h1000_0000, 8'd0});
        wait_lock("b");
        mv = 2'b00;

        // hard drop on the first fall cycle
        do_reset();
        tick();
        lock_q.push_back({32'h2000_0000, 8'd0});
        mv = 2'b11;
        tick();
        mv = 2'b00;
        check("c_drop_board", board, 32'h2000_0000);
        check("c_drop_nolock", 32'(lock), 32'h0);
        tick();
        check("c_drop_lock", 32'(lock), 32'h1);

        // fill the bottom row, then clear it
        do_reset();
        tick();
        play(2'b01, 3, 32'h1000_0000, 8'd0, "d0");
        finish_piece(0);
        play(2'b00, 0, 32'h3000_0000, 8'd0, "d1");
        finish_piece(0);
        play(2'b10, 1, 32'h7000_0000, 8'd0, "d2");
        finish_piece(0);
        play(2'b10, 2, 32'hF000_0000, 8'd0, "d3");
        tick();
        check("d_clear_board", board, 32'h0);
        check("d_clear_score", 32'(score), 32'd1);
        tick();
        check("d_done_board", board, 32'h0);
        tick();
        check("d_spawn", board, 32'h0000_0002);
        check("d_score_kept", 32'(score), 32'd1);

        // stack column 1 until spawn is blocked
        for (int k = 0; k < 8; k++) begin
            play(2'b00, 0, col_tab[k], 8'd1, "e");
            finish_piece(0);
            check("e_over", 32'(over), (k == 7) ? 32'h1 : 32'h0);
        end
        check("e_over_board", board, 32'h2222_2222);
        check("e_over_score", 32'(score), 32'd1);
        for (int i = 0; i < 20; i++) begin
            mv = 2'(i);
            tick();
            check("e_hold_board", board, 32'h2222_2222);
            check("e_hold_over", 32'(over), 32'h1);
        end
        mv = 2'b00;

        // slow gravity and asynchronous restart on the FALL_DIV=4 instance
        check("f_rst_board", board4, 32'h0);
        rst4 = 1'b0;
        tick();
        check("f_spawn", board4, 32'h0000_0002);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("f_fall", board4, (i < 4) ? 32'h0000_0002 : (i < 8) ? 32'h0000_0020 : 32'h0000_0200);
        end
        tick();
        tick();
        #2;
        rst4 = 1'b1;
        #1;
        check("f_async_board", board4, 32'h0);
        check("f_async_score", 32'(score4), 32'h0);
        check("f_async_lock", 32'(lock4), 32'h0);
        check("f_async_over", 32'(over4), 32'h0);
        @(negedge clk);
        rst4 = 1'b0;
        tick();
        check("f_restart", board4, 32'h0000_0002);

        tick();
        check("lock_queue_drained", 32'(lock_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
